// File: rtl/q88_square_seq.sv
// Sequential shift-add squarer returning the integer part of an unsigned fixed-point square.
// Optional build macro: SQUARE_ROUND_EN (round half up before the final shift; truncate otherwise).
module q88_square_seq #(
    parameter int WIDTH          = 16,
    parameter int FRAC           = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int AW    = 2 * WIDTH + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] mplier;
    logic [AW-1:0]    mcand;
    logic [AW-1:0]    acc, acc_nx, rounded, shifted;
    logic [CW-1:0]    count;
    logic             last_step;
    logic [WIDTH-1:0] result;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last_step = (count == CW'(STEPS - 1));

    // NOTE: combinational blocks use blocking assignments and give every output a default first,
    // so the partial-sum chain reads each updated value and no latch can be inferred.
    always_comb begin
        acc_nx = acc;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mplier[j]) acc_nx = acc_nx + (mcand << j);
        end
    end

`ifdef SQUARE_ROUND_EN
    // Half of one result LSB; the shift pair collapses to zero when FRAC is zero.
    localparam logic [AW-1:0] ROUND_ADD = (AW'(1) << (2 * FRAC)) >> 1;
    assign rounded = acc_nx + ROUND_ADD;
`else
    assign rounded = acc_nx;
`endif

    assign shifted = rounded >> (2 * FRAC);

    always_comb begin
        result = shifted[WIDTH-1:0];
        if (|shifted[AW-1:WIDTH]) result = '1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = CALC;
            CALC:    if (last_step) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mplier   <= '0;
            mcand    <= '0;
            acc      <= '0;
            count    <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mplier <= in_data;
                        mcand  <= AW'(in_data);
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    count  <= count + CW'(1);
                    if (last_step) out_data <= result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_q88_square_seq.sv
// Directed bench for q88_square_seq: default 1-bit/cycle instance plus a 4-bit/cycle instance.
module tb_q88_square_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data, out_data;
    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [15:0] in_data4, out_data4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    q88_square_seq #(.WIDTH(16), .FRAC(8), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    q88_square_seq #(.WIDTH(16), .FRAC(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4)
    );

    function automatic logic [15:0] model(input logic [15:0] x);
        logic [63:0] p;
        p = 64'(x) * 64'(x);
`ifdef SQUARE_ROUND_EN
        p = p + 64'h8000;
`endif
        p = p >> 16;
        return (p > 64'hFFFF) ? 16'hFFFF : p[15:0];
    endfunction

    // Launch one operand on the default instance; lat counts edges from accept to out_valid.
    task automatic do_op(input logic [15:0] x, output logic [15:0] y, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        y = out_data;
    endtask

    task automatic do_op4(input logic [15:0] x, output logic [15:0] y, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready4 && w < 50) begin @(negedge clk); w++; end
        in_valid4 = 1'b1;
        in_data4  = x;
        @(negedge clk);
        in_valid4 = 1'b0;
        in_data4  = 16'($urandom);
        lat = 0;
        while (!out_valid4 && lat < 100) begin @(negedge clk); lat++; end
        y = out_data4;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset: out_valid=%b out_data=%h in_ready=%b, need 0/0000/1",
                     out_valid, out_data, in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: out_valid=%b in_ready=%b, need 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] ops [5];
        logic [15:0] exp [5];
        logic [15:0] y;
        int          lat;
        ops = '{16'h1000, 16'h0270, 16'h0000, 16'hFFFF, 16'h0100};
`ifdef SQUARE_ROUND_EN
        exp = '{16'h0100, 16'h0006, 16'h0000, 16'hFFFE, 16'h0001};
`else
        exp = '{16'h0100, 16'h0005, 16'h0000, 16'hFFFE, 16'h0001};
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], y, lat);
            total++;
            if (y !== exp[i]) begin
                bad++;
                $display("FAIL vec_%0d: in=%h got=%h need=%h", i, ops[i], y, exp[i]);
            end
            total++;
            if (lat !== 16) begin
                bad++;
                $display("FAIL latency_%0d: got=%0d need=16", i, lat);
            end
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== exp[i]) begin
                bad++;
                $display("FAIL post_handshake_%0d: out_valid=%b in_ready=%b out_data=%h need 0/1/%h",
                         i, out_valid, in_ready, out_data, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] y;
        int          lat;
        out_ready = 1'b0;
        do_op(16'h0300, y, lat);
        total++;
        if (y !== 16'h0009 || lat !== 16) begin
            bad++;
            $display("FAIL bp_result: got=%h lat=%0d need=0009 lat=16", y, lat);
        end
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            in_data  = 16'h1234;
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'h0009 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_%0d: out_valid=%b out_data=%h in_ready=%b need 1/0009/0",
                         c, out_valid, out_data, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0009) begin
            bad++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b out_data=%h need 0/1/0009",
                     out_valid, in_ready, out_data);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [15:0] y;
        int          lat;
        int          seen;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h1000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0000) begin
            bad++;
            $display("FAIL midcalc_reset: out_valid=%b in_ready=%b out_data=%h need 0/1/0000",
                     out_valid, in_ready, out_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midcalc_no_pulse: out_valid high %0d cycles, need 0", seen);
        end
        do_op(16'h0300, y, lat);
        total++;
        if (y !== 16'h0009 || lat !== 16) begin
            bad++;
            $display("FAIL after_reset_op: got=%h lat=%0d need=0009 lat=16", y, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc, first, second, results;
        out_ready = 1'b1;
        in_data   = 16'h0100;
        first = -1; second = -1; results = 0;
        @(negedge clk);
        in_valid = 1'b1;
        for (cyc = 0; cyc < 60 && second < 0; cyc++) begin
            if (in_ready) begin
                if (first < 0) first = cyc;
                else           second = cyc;
            end
            if (out_valid && out_data === 16'h0001) results++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++;
        if (second - first !== 18 || results !== 1) begin
            bad++;
            $display("FAIL back_to_back: accept gap=%0d results=%0d need gap=18 results=1",
                     second - first, results);
        end
        repeat (25) @(negedge clk);
    endtask

    task automatic test_bpc4();
        logic [15:0] x, y, e;
        int          lat, errs, lat_errs;
        errs = 0; lat_errs = 0;
        out_ready4 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            x = (i == 0) ? 16'hFFFF : (i == 1) ? 16'h0000 : (i == 2) ? 16'h0270 : 16'($urandom);
            e = model(x);
            do_op4(x, y, lat);
            total++;
            if (y !== e) begin
                bad++;
                errs++;
                if (errs <= 5) $display("FAIL bpc4_result: in=%h got=%h need=%h", x, y, e);
            end
            if (lat !== 4) lat_errs++;
        end
        total++;
        if (lat_errs !== 0) begin
            bad++;
            $display("FAIL bpc4_latency: %0d operands off from 4 edges", lat_errs);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        test_bpc4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
